// File: rtl/data_buf_rd_seq_if.sv
// Buffer read port and downstream row stream of the data-buffer read sequencer.
// master = sequencer side, slave = buffer/consumer side.
interface data_buf_rd_seq_if #(
  parameter int unsigned ADDR_BW = 4,
  parameter int unsigned DATA_BW = 128
);
  logic               rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic [DATA_BW-1:0] rd_data;
  logic               o_valid;
  logic               o_ready;
  logic [DATA_BW-1:0] o_data;

  modport master (
    output rd_en, rd_addr, o_valid, o_data,
    input  rd_data, o_ready
  );

  modport slave (
    input  rd_en, rd_addr, o_valid, o_data,
    output rd_data, o_ready
  );
endinterface

// File: rtl/data_buf_rd_seq.sv
// Read-side sequencer: walks a row range of the data buffer into a one-entry output register.
// Define DBUF_RD_WRAP_EN for circular addressing (rd_addr wraps ROW_CNT-1 -> 0).
module data_buf_rd_seq #(
  parameter int unsigned ADDR_BW = 4,
  parameter int unsigned ROW_CNT = 16,
  parameter int unsigned DATA_BW = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base_addr,
  input  logic [ADDR_BW:0]   num_rows,
  output logic               busy,
  output logic               done,
  output logic               err,
  data_buf_rd_seq_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_BW+1:0] LP_ROWS = (ADDR_BW+2)'(ROW_CNT);
  localparam logic [ADDR_BW-1:0] LP_LAST = ADDR_BW'(ROW_CNT - 1);
  localparam logic [ADDR_BW:0]   LP_ONE  = (ADDR_BW+1)'(1);

  state_t             r_state, w_state_nxt;
  logic [ADDR_BW-1:0] r_addr,  w_addr_nxt;
  logic [ADDR_BW:0]   r_rem,   w_rem_nxt;
  logic               r_valid, w_valid_nxt;
  logic [DATA_BW-1:0] r_data,  w_data_nxt;
  logic               r_done,  w_done_nxt;
  logic               r_err,   w_err_nxt;

  logic               w_free;
  logic               w_rd_en;
  logic               w_hs;
  logic               w_num_ok;
  logic               w_base_ok;
  logic               w_cmd_ok;
  logic [ADDR_BW-1:0] w_addr_inc;

  assign w_free    = !r_valid || bus.o_ready;
  assign w_rd_en   = (r_state == S_RUN) && w_free;
  assign w_hs      = r_valid && bus.o_ready;
  assign w_num_ok  = ({1'b0, num_rows} <= LP_ROWS);
  assign w_base_ok = ({2'b00, base_addr} < LP_ROWS);

`ifdef DBUF_RD_WRAP_EN
  assign w_addr_inc = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
  assign w_cmd_ok   = w_num_ok && w_base_ok;
`else
  logic [ADDR_BW+1:0] w_end;
  assign w_end      = {2'b00, base_addr} + {1'b0, num_rows};
  assign w_addr_inc = r_addr + 1'b1;
  assign w_cmd_ok   = w_num_ok && w_base_ok && (w_end <= LP_ROWS);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    // A read refills the register in the same edge the current row leaves it.
    if (w_rd_en) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = bus.rd_data;
      w_addr_nxt  = w_addr_inc;
      w_rem_nxt   = r_rem - LP_ONE;
    end else if (w_hs) begin
      w_valid_nxt = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_cmd_ok) begin
            w_err_nxt = 1'b1;
          end else if (num_rows == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_addr_nxt  = base_addr;
            w_rem_nxt   = num_rows;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_rd_en && (r_rem == LP_ONE)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_hs) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = r_addr;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;

endmodule

// File: tb/tb_data_buf_rd_seq.sv
// Directed self-checking bench for data_buf_rd_seq; status vector is {busy,done,err,rd_en,o_valid}.
module tb_data_buf_rd_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   base_addr;
  logic [4:0]   num_rows;
  logic         busy;
  logic         done;
  logic         err;
  logic [4:0]   st;
  logic [127:0] got_q[$];

  int checks   = 0;
  int failures = 0;

  data_buf_rd_seq_if #(.ADDR_BW(4), .DATA_BW(128)) bus ();

  data_buf_rd_seq #(.ADDR_BW(4), .ROW_CNT(16), .DATA_BW(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus.master)
  );

  function automatic logic [127:0] row_val(input logic [3:0] a);
    return {4{28'hABCDE00, a}};
  endfunction

  assign bus.rd_data = row_val(bus.rd_addr);
  assign st = {busy, done, err, bus.rd_en, bus.o_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moves to the input-drive slot of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; bus.o_ready = 1'b1;
    #3;
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL reset_status got=%b exp=%b", st, 5'b00000); end
    checks++;
    if (bus.rd_addr !== 4'd0 || bus.o_data !== 128'd0) begin
      failures++; $display("FAIL reset_data got addr=%0d data=%h exp 0", bus.rd_addr, bus.o_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [4:0] exp;
    start = 1'b1; base_addr = 4'd2; num_rows = 5'd4; bus.o_ready = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      exp = {(c >= 1 && c <= 5), (c == 6), 1'b0, (c <= 4), (c >= 2 && c <= 5)};
      checks++;
      if (st !== exp) begin failures++; $display("FAIL basic_status cyc=%0d got=%b exp=%b", c, st, exp); end
      if (c <= 4) begin
        checks++;
        if (bus.rd_addr !== 4'(c + 1)) begin failures++; $display("FAIL basic_addr cyc=%0d got=%0d exp=%0d", c, bus.rd_addr, c + 1); end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (bus.o_data !== row_val(4'(c))) begin failures++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", c, bus.o_data, row_val(4'(c))); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [8:1] rdy;
    logic [4:0] st_tab [1:8];
    int         dix    [1:8];
    rdy    = 8'b1110_0011;
    st_tab = '{5'b10010, 5'b10011, 5'b10001, 5'b10001, 5'b10001, 5'b10011, 5'b10001, 5'b01000};
    dix    = '{-1, 0, 1, 1, 1, 1, 2, -1};
    got_q.delete();
    start = 1'b1; base_addr = 4'd0; num_rows = 5'd3; bus.o_ready = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.o_ready = rdy[c];
      #1;
      checks++;
      if (st !== st_tab[c]) begin failures++; $display("FAIL bp_status cyc=%0d got=%b exp=%b", c, st, st_tab[c]); end
      if (dix[c] >= 0) begin
        checks++;
        if (bus.o_data !== row_val(4'(dix[c]))) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, bus.o_data, row_val(4'(dix[c]))); end
      end
      if (bus.o_valid && bus.o_ready) got_q.push_back(bus.o_data);
      tick();
    end
    bus.o_ready = 1'b1;
    checks++;
    if (got_q.size() !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== row_val(4'(i))) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], row_val(4'(i))); end
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    logic [4:0] st_tab [1:6];
    int         n_done;
    start = 1'b1; base_addr = 4'd3; num_rows = 5'd0;
    tick(); start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (st !== ((c == 1) ? 5'b01000 : 5'b00000)) begin failures++; $display("FAIL zero_status cyc=%0d got=%b", c, st); end
      tick();
    end
    st_tab = '{5'b10010, 5'b10011, 5'b10001, 5'b01000, 5'b00000, 5'b00000};
    n_done = 0;
    start = 1'b1; base_addr = 4'd0; num_rows = 5'd2;
    tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin start = 1'b1; base_addr = 4'd5; num_rows = 5'd3; end
      else start = 1'b0;
      #1;
      checks++;
      if (st !== st_tab[c]) begin failures++; $display("FAIL ignore_status cyc=%0d got=%b exp=%b", c, st, st_tab[c]); end
      if (done) n_done++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_range();
    logic [3:0] exp_a [1:4];
    start = 1'b1; base_addr = 4'd0; num_rows = 5'd17;
    tick(); start = 1'b0;
    #1;
    checks++;
    if (st !== 5'b00100) begin failures++; $display("FAIL range_num_err got=%b exp=%b", st, 5'b00100); end
    tick();
    start = 1'b1; base_addr = 4'd14; num_rows = 5'd4;
    tick(); start = 1'b0;
`ifdef DBUF_RD_WRAP_EN
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
`else
    #1;
    checks++;
    if (st !== 5'b00100) begin failures++; $display("FAIL range_err_pulse got=%b exp=%b", st, 5'b00100); end
    tick(); #1;
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL range_err_clear got=%b exp=%b", st, 5'b00000); end
    tick();
    exp_a = '{4'd12, 4'd13, 4'd14, 4'd15};
    start = 1'b1; base_addr = 4'd12; num_rows = 5'd4;
    tick(); start = 1'b0;
`endif
    got_q.delete();
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c <= 4) begin
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== exp_a[c]) begin
          failures++; $display("FAIL range_addr cyc=%0d got en=%b addr=%0d exp addr=%0d", c, bus.rd_en, bus.rd_addr, exp_a[c]);
        end
      end
      if (bus.o_valid && bus.o_ready) got_q.push_back(bus.o_data);
      if (c == 6) begin
        checks++;
        if (st !== 5'b01000) begin failures++; $display("FAIL range_done got=%b exp=%b", st, 5'b01000); end
      end
      tick();
    end
    checks++;
    if (got_q.size() !== 4) begin failures++; $display("FAIL range_count got=%0d exp=4", got_q.size()); end
    else if (got_q[3] !== row_val(exp_a[4]) || got_q[0] !== row_val(exp_a[1])) begin
      failures++; $display("FAIL range_rows got first=%h last=%h", got_q[0], got_q[3]);
    end
  endtask

  task automatic test_reset_midop();
    logic [4:0] st_tab [1:4];
    start = 1'b1; base_addr = 4'd0; num_rows = 5'd6;
    tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 5'b00000 || bus.rd_addr !== 4'd0 || bus.o_data !== 128'd0) begin
      failures++; $display("FAIL midop_reset got st=%b addr=%0d data=%h exp all 0", st, bus.rd_addr, bus.o_data);
    end
    rst_n = 1'b1;
    tick(); #1;
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL midop_no_done got=%b exp=%b", st, 5'b00000); end
    st_tab = '{5'b10010, 5'b10011, 5'b10001, 5'b01000};
    start = 1'b1; base_addr = 4'd0; num_rows = 5'd2;
    tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (st !== st_tab[c]) begin failures++; $display("FAIL midop_status cyc=%0d got=%b exp=%b", c, st, st_tab[c]); end
      if (c == 2 || c == 3) begin
        checks++;
        if (bus.o_data !== row_val(4'(c - 2))) begin failures++; $display("FAIL midop_data cyc=%0d got=%h exp=%h", c, bus.o_data, row_val(4'(c - 2))); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] st_tab [1:4];
    st_tab = '{5'b10010, 5'b10011, 5'b10001, 5'b01000};
    start = 1'b1; base_addr = 4'd4; num_rows = 5'd2;
    tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin start = 1'b1; base_addr = 4'd8; num_rows = 5'd1; end
      #1;
      checks++;
      if (st !== st_tab[c]) begin failures++; $display("FAIL b2b_first cyc=%0d got=%b exp=%b", c, st, st_tab[c]); end
      tick();
    end
    start = 1'b0;
    #1;
    checks++;
    if (st !== 5'b10010 || bus.rd_addr !== 4'd8) begin
      failures++; $display("FAIL b2b_accept got st=%b addr=%0d exp st=10010 addr=8", st, bus.rd_addr);
    end
    tick(); #1;
    checks++;
    if (st !== 5'b10001 || bus.o_data !== row_val(4'd8)) begin
      failures++; $display("FAIL b2b_row got st=%b data=%h exp st=10001 data=%h", st, bus.o_data, row_val(4'd8));
    end
    tick(); #1;
    checks++;
    if (st !== 5'b01000) begin failures++; $display("FAIL b2b_done got=%b exp=%b", st, 5'b01000); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_and_ignore();
    test_range();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
